// File: rtl/modulo_encaixotador_duzias.sv
// +----------------------------------------------------------------------------+
// | Module   : modulo_encaixotador_duzias                                      |
// | Purpose  : Packs sealed bottles into boxes of one dozen, requests box      |
// |            ejection with a req/ack handshake, counts boxes on the pallet   |
// |            in BCD and stalls the sealing station when it cannot accept     |
// |            more bottles.                                                   |
// | Optional : `define ENCAIXOTADOR_TIMEOUT_EN adds an ejection timeout that   |
// |            raises erro_timeout and parks the FSM in IDLE until reset.      |
// | Ports    : clk, reset (sync, active-high), enable, garrafa_vedada,         |
// |            eject_ack, palete_removido -> eject_req, bloqueio,              |
// |            palete_cheio, erro_overflow, erro_timeout, garrafas_caixa[3:0], |
// |            caixas_dezena[3:0], caixas_unidade[3:0], estado[1:0]            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module modulo_encaixotador_duzias #(
  parameter int GARRAFAS_POR_CAIXA = 12,
  parameter int CAIXAS_POR_PALETE  = 10,
  parameter int TIMEOUT_EJECAO     = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       garrafa_vedada,
  input  logic       eject_ack,
  input  logic       palete_removido,
  output logic       eject_req,
  output logic       bloqueio,
  output logic       palete_cheio,
  output logic       erro_overflow,
  output logic       erro_timeout,
  output logic [3:0] garrafas_caixa,
  output logic [3:0] caixas_dezena,
  output logic [3:0] caixas_unidade,
  output logic [1:0] estado
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ENCHENDO = 2'b01,
    EJETANDO = 2'b10,
    PALETE   = 2'b11
  } state_t;

  localparam logic [3:0] GARRAFAS_MAX   = 4'(GARRAFAS_POR_CAIXA - 1);
  localparam logic [3:0] GARRAFAS_CAIXA = 4'(GARRAFAS_POR_CAIXA);
  localparam logic [3:0] META_DEZENA    = 4'(CAIXAS_POR_PALETE / 10);
  localparam logic [3:0] META_UNIDADE   = 4'(CAIXAS_POR_PALETE % 10);

  // Elaboration-time range guard on the configuration.
  if ((GARRAFAS_POR_CAIXA < 2) || (GARRAFAS_POR_CAIXA > 15) ||
      (CAIXAS_POR_PALETE < 1) || (CAIXAS_POR_PALETE > 99) ||
      (TIMEOUT_EJECAO < 1)) begin : g_param_invalid
    $error("modulo_encaixotador_duzias: parameter out of range");
  end

  state_t     state, state_next;
  logic       garrafa_prev;
  logic       pulso;
  logic [3:0] garrafas, garrafas_next;
  logic [1:0] pendentes, pendentes_next;
  logic [3:0] dezena, dezena_next, unidade, unidade_next;
  logic       overflow, overflow_next;
  logic       travado;

  // Box count + 1, in BCD, and whether that closes the pallet.
  logic [3:0] dezena_inc, unidade_inc;
  logic       caixa_final;

  // Bottles held back while ejecting/pallet-full, plus a same-cycle pulse.
  logic [2:0] carga;
  logic       carga_cheia;
  logic [1:0] carga_resto;
  logic [1:0] acum_pend;
  logic       acum_ovf;

  assign pulso = garrafa_vedada & ~garrafa_prev;

  always_comb begin
    dezena_inc  = dezena;
    unidade_inc = unidade + 4'd1;
    if (unidade == 4'd9) begin
      unidade_inc = 4'd0;
      dezena_inc  = dezena + 4'd1;
    end
  end

  assign caixa_final = (dezena_inc == META_DEZENA) && (unidade_inc == META_UNIDADE);

  assign carga       = {1'b0, pendentes} + {2'b00, pulso};
  assign carga_cheia = ({1'b0, carga} >= GARRAFAS_CAIXA);
  // Only meaningful when carga_cheia, which requires a box of at most 4.
  assign carga_resto = carga[1:0] - GARRAFAS_CAIXA[1:0];

  assign acum_pend = (pulso && (pendentes != 2'd3)) ? pendentes + 2'd1 : pendentes;
  assign acum_ovf  = pulso && (pendentes == 2'd3);

`ifdef ENCAIXOTADOR_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_EJECAO + 1);
  logic [WAIT_W-1:0] espera, espera_next;
  logic              timeout, timeout_next;
  assign travado      = timeout;
  assign erro_timeout = timeout;
`else
  assign travado      = 1'b0;
  assign erro_timeout = 1'b0;
`endif

  always_comb begin
    state_next     = state;
    garrafas_next  = garrafas;
    pendentes_next = pendentes;
    dezena_next    = dezena;
    unidade_next   = unidade;
    overflow_next  = overflow;
`ifdef ENCAIXOTADOR_TIMEOUT_EN
    espera_next    = '0;
    timeout_next   = timeout;
`endif
    case (state)
      IDLE: begin
        // After a timeout the station stays parked here until reset.
        if (enable && !travado) state_next = ENCHENDO;
      end
      ENCHENDO: begin
        if (enable && pulso) begin
          if (garrafas == GARRAFAS_MAX) begin
            garrafas_next = 4'd0;
            state_next    = EJETANDO;
          end else begin
            garrafas_next = garrafas + 4'd1;
          end
        end
      end
      EJETANDO: begin
        if (eject_ack) begin
          dezena_next  = dezena_inc;
          unidade_next = unidade_inc;
          if (caixa_final) begin
            state_next     = PALETE;
            pendentes_next = acum_pend;
            if (acum_ovf) overflow_next = 1'b1;
          end else if (carga_cheia) begin
            garrafas_next  = 4'd0;
            pendentes_next = carga_resto;
            state_next     = EJETANDO;
          end else begin
            garrafas_next  = {1'b0, carga};
            pendentes_next = 2'd0;
            state_next     = ENCHENDO;
          end
        end else begin
          pendentes_next = acum_pend;
          if (acum_ovf) overflow_next = 1'b1;
`ifdef ENCAIXOTADOR_TIMEOUT_EN
          if (espera == WAIT_W'(TIMEOUT_EJECAO)) begin
            timeout_next = 1'b1;
            state_next   = IDLE;
          end else begin
            espera_next = espera + 1'b1;
          end
`endif
        end
      end
      PALETE: begin
        if (palete_removido) begin
          dezena_next  = 4'd0;
          unidade_next = 4'd0;
          if (carga_cheia) begin
            garrafas_next  = 4'd0;
            pendentes_next = carga_resto;
            state_next     = EJETANDO;
          end else begin
            garrafas_next  = {1'b0, carga};
            pendentes_next = 2'd0;
            state_next     = ENCHENDO;
          end
        end else begin
          pendentes_next = acum_pend;
          if (acum_ovf) overflow_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      garrafa_prev <= 1'b0;
      garrafas     <= 4'd0;
      pendentes    <= 2'd0;
      dezena       <= 4'd0;
      unidade      <= 4'd0;
      overflow     <= 1'b0;
`ifdef ENCAIXOTADOR_TIMEOUT_EN
      espera       <= '0;
      timeout      <= 1'b0;
`endif
    end else begin
      state        <= state_next;
      garrafa_prev <= garrafa_vedada;
      garrafas     <= garrafas_next;
      pendentes    <= pendentes_next;
      dezena       <= dezena_next;
      unidade      <= unidade_next;
      overflow     <= overflow_next;
`ifdef ENCAIXOTADOR_TIMEOUT_EN
      espera       <= espera_next;
      timeout      <= timeout_next;
`endif
    end
  end

  assign eject_req      = (state == EJETANDO);
  assign palete_cheio   = (state == PALETE);
  assign bloqueio       = (pendentes == 2'd3) || (state == PALETE) || travado;
  assign erro_overflow  = overflow;
  assign garrafas_caixa = garrafas;
  assign caixas_dezena  = dezena;
  assign caixas_unidade = unidade;
  assign estado         = state;

endmodule

`default_nettype wire

// File: tb/tb_modulo_encaixotador_duzias.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_modulo_encaixotador_duzias                                   |
// | Purpose  : Self-checking bench: a vector table of {inputs, expected        |
// |            outputs} is applied one cycle per row, expectations go through  |
// |            a scoreboard queue, and a few hand-written sequences cover the  |
// |            long ejection wait and reset during the handshake.             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_modulo_encaixotador_duzias;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       garrafa_vedada = 1'b0;
  logic       eject_ack = 1'b0;
  logic       palete_removido = 1'b0;
  logic       eject_req, bloqueio, palete_cheio, erro_overflow, erro_timeout;
  logic [3:0] garrafas_caixa, caixas_dezena, caixas_unidade;
  logic [1:0] estado;

  always #5 clk = ~clk;

  modulo_encaixotador_duzias dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .garrafa_vedada  (garrafa_vedada),
    .eject_ack       (eject_ack),
    .palete_removido (palete_removido),
    .eject_req       (eject_req),
    .bloqueio        (bloqueio),
    .palete_cheio    (palete_cheio),
    .erro_overflow   (erro_overflow),
    .erro_timeout    (erro_timeout),
    .garrafas_caixa  (garrafas_caixa),
    .caixas_dezena   (caixas_dezena),
    .caixas_unidade  (caixas_unidade),
    .estado          (estado)
  );

  typedef struct packed {
    logic [3:0] garrafas;
    logic [1:0] estado;
    logic       eject;
    logic       bloq;
    logic       cheio;
    logic       ovf;
    logic       tmo;
    logic [3:0] dez;
    logic [3:0] uni;
  } out_t;

  typedef struct {
    logic rst;
    logic en;
    logic g;
    logic ack;
    logic rem;
    out_t exp;
  } vec_t;

  vec_t vecs[$];
  out_t sb_q[$];
  int   checks = 0;
  int   passed = 0;

  function automatic out_t mk(input int gc, input int es, input int ej, input int bl,
                              input int ch, input int ov, input int dz, input int un);
    out_t o;
    o.garrafas = 4'(gc);
    o.estado   = 2'(es);
    o.eject    = 1'(ej);
    o.bloq     = 1'(bl);
    o.cheio    = 1'(ch);
    o.ovf      = 1'(ov);
    o.tmo      = 1'b0;
    o.dez      = 4'(dz);
    o.uni      = 4'(un);
    return o;
  endfunction

  function automatic void add(input logic rst, input logic en, input logic g,
                              input logic ack, input logic rem, input out_t e);
    vec_t x;
    x.rst = rst; x.en = en; x.g = g; x.ack = ack; x.rem = rem; x.exp = e;
    vecs.push_back(x);
  endfunction

  // One separated bottle: sensor high for a cycle, then low; outputs hold.
  function automatic void pulse(input logic en, input out_t e);
    add(1'b0, en, 1'b1, 1'b0, 1'b0, e);
    add(1'b0, en, 1'b0, 1'b0, 1'b0, e);
  endfunction

  function automatic out_t sample();
    out_t a;
    a.garrafas = garrafas_caixa;
    a.estado   = estado;
    a.eject    = eject_req;
    a.bloq     = bloqueio;
    a.cheio    = palete_cheio;
    a.ovf      = erro_overflow;
    a.tmo      = erro_timeout;
    a.dez      = caixas_dezena;
    a.uni      = caixas_unidade;
    return a;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    out_t e, a;
    int   s;
    bit   seen;

    // ---------------- vector table ----------------
    add(1, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    add(1, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    pulse(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0));               // IDLE ignores pulses
    add(0, 1, 0, 0, 0, mk(0, 1, 0, 0, 0, 0, 0, 0));        // enable -> ENCHENDO
    for (int i = 1; i <= 11; i++) pulse(1'b1, mk(i, 1, 0, 0, 0, 0, 0, 0));
    pulse(1'b1, mk(0, 2, 1, 0, 0, 0, 0, 0));               // 12th: box full
    // two pulses while ejecting, then ack
    pulse(1'b1, mk(0, 2, 1, 0, 0, 0, 0, 0));
    pulse(1'b1, mk(0, 2, 1, 0, 0, 0, 0, 0));
    add(0, 1, 0, 1, 0, mk(2, 1, 0, 0, 0, 0, 0, 1));
    // fill second box, then four pulses without ack
    for (int i = 3; i <= 11; i++) pulse(1'b1, mk(i, 1, 0, 0, 0, 0, 0, 1));
    pulse(1'b1, mk(0, 2, 1, 0, 0, 0, 0, 1));
    pulse(1'b1, mk(0, 2, 1, 0, 0, 0, 0, 1));
    pulse(1'b1, mk(0, 2, 1, 0, 0, 0, 0, 1));
    pulse(1'b1, mk(0, 2, 1, 1, 0, 0, 0, 1));               // pending = 3 stalls
    pulse(1'b1, mk(0, 2, 1, 1, 0, 1, 0, 1));               // lost bottle
    add(0, 1, 0, 1, 0, mk(3, 1, 0, 0, 0, 1, 0, 2));
    // third box; pulse + ack in the same cycle with pending = 1
    for (int i = 4; i <= 11; i++) pulse(1'b1, mk(i, 1, 0, 0, 0, 1, 0, 2));
    pulse(1'b1, mk(0, 2, 1, 0, 0, 1, 0, 2));
    pulse(1'b1, mk(0, 2, 1, 0, 0, 1, 0, 2));
    add(0, 1, 1, 1, 0, mk(2, 1, 0, 0, 0, 1, 0, 3));
    add(0, 1, 0, 0, 0, mk(2, 1, 0, 0, 0, 1, 0, 3));
    // boxes 4..10 with immediate acks, tenth box fills the pallet
    for (int b = 4; b <= 10; b++) begin
      s = (b == 4) ? 2 : 0;
      for (int k = s + 1; k <= 11; k++) pulse(1'b1, mk(k, 1, 0, 0, 0, 1, 0, b - 1));
      pulse(1'b1, mk(0, 2, 1, 0, 0, 1, 0, b - 1));
      if (b < 10) add(0, 1, 0, 1, 0, mk(0, 1, 0, 0, 0, 1, 0, b));
      else        add(0, 1, 0, 1, 0, mk(0, 3, 0, 1, 1, 1, 1, 0));
    end
    // pallet full: pulse goes to pending, stray ack ignored, then removal
    pulse(1'b1, mk(0, 3, 0, 1, 1, 1, 1, 0));
    add(0, 1, 0, 1, 0, mk(0, 3, 0, 1, 1, 1, 1, 0));
    add(0, 1, 0, 0, 1, mk(1, 1, 0, 0, 0, 1, 0, 0));
    add(0, 1, 0, 0, 1, mk(1, 1, 0, 0, 0, 1, 0, 0));        // removal outside PALETE
    pulse(1'b0, mk(1, 1, 0, 0, 0, 1, 0, 0));               // enable low holds
    for (int i = 2; i <= 11; i++) pulse(1'b1, mk(i, 1, 0, 0, 0, 1, 0, 0));
    pulse(1'b1, mk(0, 2, 1, 0, 0, 1, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset           = vecs[i].rst;
      enable          = vecs[i].en;
      garrafa_vedada  = vecs[i].g;
      eject_ack       = vecs[i].ack;
      palete_removido = vecs[i].rem;
      sb_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      a = sample();
      e = sb_q.pop_front();
      checks++;
      if (a == e) passed++;
      else $display("FAIL vec%0d: got g=%0d st=%0d req=%0d blq=%0d full=%0d ovf=%0d tmo=%0d bcd=%0d%0d expected g=%0d st=%0d req=%0d blq=%0d full=%0d ovf=%0d tmo=%0d bcd=%0d%0d",
                    i, a.garrafas, a.estado, a.eject, a.bloq, a.cheio, a.ovf, a.tmo, a.dez, a.uni,
                    e.garrafas, e.estado, e.eject, e.bloq, e.cheio, e.ovf, e.tmo, e.dez, e.uni);
    end

    // ---------------- long wait for an ack that never comes ----------------
    @(negedge clk);
    enable = 1'b1; garrafa_vedada = 1'b0; eject_ack = 1'b0; palete_removido = 1'b0;
`ifdef ENCAIXOTADOR_TIMEOUT_EN
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      if (estado == 2'b00) seen = 1'b1;
    end
    check("timeout_reached_idle", int'(seen), 1);
    check("timeout_err", int'(erro_timeout), 1);
    check("timeout_req_dropped", int'(eject_req), 0);
    check("timeout_stall", int'(bloqueio), 1);
    repeat (5) @(negedge clk);
    check("timeout_stays_idle", int'(estado), 0);
`else
    seen = 1'b0;
    repeat (1000) @(negedge clk);
    check("wait_req_held", int'(eject_req), 1);
    check("wait_state", int'(estado), 2);
    check("wait_no_timeout", int'(erro_timeout), 0);
`endif

    // ---------------- reset during the handshake ----------------
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_req", int'(eject_req), 0);
    check("rst_state", int'(estado), 0);
    check("rst_ovf", int'(erro_overflow), 0);
    check("rst_tmo", int'(erro_timeout), 0);
    check("rst_bcd", int'({caixas_dezena, caixas_unidade}), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_enchendo", int'(estado), 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
